// File: rtl/audio_param_sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// audio_param_sync_fifo_pkg
//   Shared definitions for the audio sample FIFO: default geometry and
//   threshold constants, the per-cycle operation encoding used by the
//   occupancy logic, and a ceil(log2) helper for callers that size ports
//   from a depth.
// ---------------------------------------------------------------------------
package audio_param_sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_AFULL_LVL  = 120;
    localparam int DEF_AEMPTY_LVL = 8;

    // Accepted-operation code for one clock: {push_accepted, pop_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Ceiling log2, returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int v;
        int result;
        v      = value - 1;
        result = 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// ---------------------------------------------------------------------------
// audio_fifo_ram
//   Simple dual-port RAM with one write port and one registered read port,
//   written so synthesis maps it onto an embedded memory block.
//
//   Ports
//     i_clk     rising-edge clock
//     i_rst     synchronous clear of the read register (array is not cleared)
//     i_we      write enable
//     i_waddr   write address
//     i_wdata   write data
//     i_re      read enable; the read register holds when low
//     i_raddr   read address
//     o_rdata   registered read data
//
//   WRITE_FIRST=1 returns the word being written when the read and write
//   addresses collide on the same edge; WRITE_FIRST=0 returns the word that
//   was stored before the write.
// ---------------------------------------------------------------------------
module audio_fifo_ram
    import audio_param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_collide;

    assign w_collide = WRITE_FIRST && i_we && (i_waddr == i_raddr);

    // Storage array write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port with optional new-data forwarding on collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (w_collide) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/audio_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// audio_param_sync_fifo
//   Single-clock FIFO for audio sample buffering. Holds read/write pointers,
//   a separate occupancy counter, registered status flags and sticky error
//   flags; the data lives in audio_fifo_ram, whose read register is also the
//   read_data output register.
//
//   Ports
//     i_clk            rising-edge clock
//     i_reset          synchronous active-high reset
//     i_clear          synchronous flush, identical effect to reset
//     i_write_en       push request
//     i_write_data     push data
//     i_read_en        pop request
//     o_read_data      head word (show-ahead) / last popped word (normal)
//     o_read_valid     normal mode: pulses the cycle after an accepted pop;
//                      show-ahead mode: !empty
//     o_fifo_is_empty  no words stored
//     o_fifo_is_full   words_used == depth
//     o_almost_empty   words_used <= AEMPTY_LVL
//     o_almost_full    words_used >= AFULL_LVL
//     o_words_used     occupancy 0..depth
//     o_overflow       sticky: write rejected because full
//     o_underflow      sticky: read requested while empty
// ---------------------------------------------------------------------------
module audio_param_sync_fifo
    import audio_param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SHOW_AHEAD = 1,
    parameter int AFULL_LVL  = DEF_AFULL_LVL,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_write_en,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_read_en,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_read_valid,
    output logic                  o_fifo_is_empty,
    output logic                  o_fifo_is_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_words_used,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AFULL  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] CNT_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_LVL);

    // Threshold ordering must leave a meaningful band between the two flags.
    if (!((AEMPTY_LVL < AFULL_LVL) && (AFULL_LVL <= DEPTH))) begin : g_bad_levels
        $error("audio_param_sync_fifo: need AEMPTY_LVL < AFULL_LVL <= 2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_aempty;
    logic                  r_afull;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_rd_valid;

    logic                  w_flush;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    fifo_op_e              w_op;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [ADDR_WIDTH-1:0] w_ram_raddr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // A pop frees a slot on the same edge, so a full FIFO still takes a
    // write when a read is accepted alongside it.
    assign w_flush      = i_reset | i_clear;
    assign w_pop_ok     = i_read_en & ~r_empty;
    assign w_push_ok    = i_write_en & (~r_full | w_pop_ok);
    assign w_op         = fifo_op_e'({w_push_ok, w_pop_ok});
    assign w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(w_pop_ok);
    assign w_wr_ptr_nxt = r_wr_ptr + ADDR_WIDTH'(w_push_ok);

    // Occupancy update from the accepted-operation code.
    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_PUSH: w_count_nxt = r_count + CNT_ONE;
            OP_POP:  w_count_nxt = r_count - CNT_ONE;
            OP_IDLE: w_count_nxt = r_count;
            OP_BOTH: w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // RAM read control. Show-ahead keeps the read register loaded with the
    // word that will be at the head after this edge; a word written into
    // that slot on the same edge is forwarded by the RAM's write-first path.
    // Normal mode reads the slot being popped, only on an accepted pop.
    always_comb begin
        w_ram_raddr = r_rd_ptr;
        w_ram_re    = 1'b0;
        if (SHOW_AHEAD != 0) begin
            w_ram_raddr = w_rd_ptr_nxt;
            w_ram_re    = (w_push_ok | w_pop_ok) & ~w_flush;
        end else begin
            w_ram_raddr = r_rd_ptr;
            w_ram_re    = w_pop_ok & ~w_flush;
        end
    end

    assign w_ram_we = w_push_ok & ~w_flush;

    // Normal mode must return the stored word on full+push+pop, when the
    // write lands on the slot being popped, so forwarding is show-ahead only.
    audio_fifo_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WRITE_FIRST (SHOW_AHEAD != 0)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (w_flush),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_write_data),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // Pointers, occupancy and status flags; flush wins over any request.
    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= CNT_ZERO;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_aempty    <= 1'b1;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == CNT_ZERO);
            r_full      <= (w_count_nxt == CNT_DEPTH);
            r_aempty    <= (w_count_nxt <= CNT_AEMPTY);
            r_afull     <= (w_count_nxt >= CNT_AFULL);
            r_overflow  <= r_overflow | (i_write_en & ~w_push_ok);
            r_underflow <= r_underflow | (i_read_en & r_empty);
            r_rd_valid  <= w_pop_ok;
        end
    end

    assign o_read_data     = w_ram_rdata;
    assign o_read_valid    = (SHOW_AHEAD != 0) ? ~r_empty : r_rd_valid;
    assign o_fifo_is_empty = r_empty;
    assign o_fifo_is_full  = r_full;
    assign o_almost_empty  = r_aempty;
    assign o_almost_full   = r_afull;
    assign o_words_used    = r_count;
    assign o_overflow      = r_overflow;
    assign o_underflow     = r_underflow;

endmodule

// File: tb/tb_audio_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_audio_param_sync_fifo
//   Two instances (show-ahead and normal read mode) share one stimulus
//   stream. A queue-based reference model tracks contents and flags; hand
//   expectations cover reset, fill/drain, overflow, underflow, flush
//   priority, simultaneous push/pop at full and across pointer wrap.
// ---------------------------------------------------------------------------
module tb_audio_param_sync_fifo;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          write_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_en = 1'b0;

    logic [DW-1:0] a_rd, b_rd;
    logic          a_rv, b_rv, a_empty, b_empty, a_full, b_full;
    logic          a_aempty, b_aempty, a_afull, b_afull;
    logic [AW:0]   a_used, b_used;
    logic          a_ovf, b_ovf, a_udf, b_udf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_b_rd = '0;
    logic          m_b_rv = 1'b0;

    always #5 clk = ~clk;

    audio_param_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(1), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
    ) dut_sa (
        .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_write_en(write_en),
        .i_write_data(write_data), .i_read_en(read_en), .o_read_data(a_rd),
        .o_read_valid(a_rv), .o_fifo_is_empty(a_empty), .o_fifo_is_full(a_full),
        .o_almost_empty(a_aempty), .o_almost_full(a_afull), .o_words_used(a_used),
        .o_overflow(a_ovf), .o_underflow(a_udf)
    );

    audio_param_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(0), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
    ) dut_nm (
        .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_write_en(write_en),
        .i_write_data(write_data), .i_read_en(read_en), .o_read_data(b_rd),
        .o_read_valid(b_rv), .o_fifo_is_empty(b_empty), .o_fifo_is_full(b_full),
        .o_almost_empty(b_aempty), .o_almost_full(b_afull), .o_words_used(b_used),
        .o_overflow(b_ovf), .o_underflow(b_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one update per clock edge from pre-edge state.
    task automatic model_update(input logic we, input logic [DW-1:0] wd,
                                input logic re, input logic clr, input logic rst);
        bit pop_ok, push_ok;
        if (rst || clr) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_b_rd = '0; m_b_rv = 1'b0;
        end else begin
            pop_ok  = re && (mq.size() != 0);
            push_ok = we && ((mq.size() < DEPTH) || pop_ok);
            if (we && !push_ok) m_ovf = 1'b1;
            if (re && (mq.size() == 0)) m_udf = 1'b1;
            m_b_rv = pop_ok;
            if (pop_ok) m_b_rd = mq.pop_front();
            if (push_ok) mq.push_back(wd);
        end
    endtask

    task automatic cmp_model();
        int n;
        n = mq.size();
        chk("words_used", 32'(a_used), n);
        chk("words_used_nm", 32'(b_used), n);
        chk("empty", 32'(a_empty), 32'(n == 0));
        chk("full", 32'(a_full), 32'(n == DEPTH));
        chk("almost_empty", 32'(a_aempty), 32'(n <= AEL));
        chk("almost_full", 32'(a_afull), 32'(n >= AFL));
        chk("overflow", 32'(a_ovf), 32'(m_ovf));
        chk("underflow", 32'(a_udf), 32'(m_udf));
        chk("sa_read_valid", 32'(a_rv), 32'(n != 0));
        if (n != 0) chk("sa_head", 32'(a_rd), 32'(mq[0]));
        chk("nm_read_valid", 32'(b_rv), 32'(m_b_rv));
        chk("nm_read_data", 32'(b_rd), 32'(m_b_rd));
    endtask

    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic clr, input logic rst);
        @(negedge clk);
        write_en = we; write_data = wd; read_en = re; clear = clr; reset = rst;
        @(posedge clk);
        #1;
        model_update(we, wd, re, clr, rst);
        cmp_model();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_used"}, 32'(a_used), 32'd0);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_aempty"}, 32'(a_aempty), 32'd1);
        chk({tag, "_full"}, 32'(a_full), 32'd0);
        chk({tag, "_afull"}, 32'(a_afull), 32'd0);
        chk({tag, "_ovf"}, 32'(a_ovf), 32'd0);
        chk({tag, "_udf"}, 32'(a_udf), 32'd0);
        chk({tag, "_sa_rv"}, 32'(a_rv), 32'd0);
        chk({tag, "_nm_rv"}, 32'(b_rv), 32'd0);
        chk({tag, "_sa_rd"}, 32'(a_rd), 32'd0);
        chk({tag, "_nm_rd"}, 32'(b_rd), 32'd0);
    endtask

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          clr;
        int            exp_used;
        logic          exp_ovf;
        logic          exp_udf;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 16'h00AA, 1'b1, 1'b0, 1, 1'b0, 1'b1, 16'h00AA};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16'h0000};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16'h0000};
        tbl[3] = '{1'b1, 16'h0055, 1'b0, 1'b0, 1, 1'b0, 1'b1, 16'h0055};
        tbl[4] = '{1'b1, 16'h0066, 1'b1, 1'b0, 1, 1'b0, 1'b1, 16'h0066};
        tbl[5] = '{1'b1, 16'h0077, 1'b1, 1'b1, 0, 1'b0, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 16'h0088, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'h0088};

        // Reset
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk_reset_state("reset");

        // Fill to full, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("t1_full", 32'(a_full), 32'd1);
        chk("t1_used", 32'(a_used), 32'd8);
        chk("t1_afull", 32'(a_afull), 32'd1);
        chk("t1_head", 32'(a_rd), 32'h0001);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            chk("t1_pop_data", 32'(b_rd), 32'(i));
        end
        chk("t1_empty", 32'(a_empty), 32'd1);

        // Overflow on full, rejected word never read, clear drops sticky flag
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("t2_ovf", 32'(a_ovf), 32'd1);
        chk("t2_used", 32'(a_used), 32'd8);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            chk("t2_pop_data", 32'(b_rd), 32'(i));
        end
        chk("t2_ovf_sticky", 32'(a_ovf), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("t2_clr_ovf", 32'(a_ovf), 32'd0);
        chk("t2_clr_empty", 32'(a_empty), 32'd1);

        // Table: underflow with same-cycle write, bypass, flush priority
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].we, tbl[k].wd, tbl[k].re, tbl[k].clr, 1'b0);
            chk($sformatf("tbl%0d_used", k), 32'(a_used), 32'(tbl[k].exp_used));
            chk($sformatf("tbl%0d_ovf", k), 32'(a_ovf), 32'(tbl[k].exp_ovf));
            chk($sformatf("tbl%0d_udf", k), 32'(a_udf), 32'(tbl[k].exp_udf));
            if (tbl[k].exp_used != 0)
                chk($sformatf("tbl%0d_rd", k), 32'(a_rd), 32'(tbl[k].exp_rd));
        end

        // Full with simultaneous push/pop, pointers offset so storage wraps
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
        chk("t4_used", 32'(a_used), 32'd8);
        chk("t4_ovf", 32'(a_ovf), 32'd0);
        chk("t4_pop1", 32'(b_rd), 32'h0001);
        chk("t4_head", 32'(a_rd), 32'h0002);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            chk("t4_drain", 32'(b_rd), 32'(i + 1));
        end

        // Normal mode: read_valid pulse then hold
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("t5_rv_before", 32'(b_rv), 32'd0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("t5_rv", 32'(b_rv), 32'd1);
        chk("t5_rd", 32'(b_rd), 32'h1234);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t5_rv_drop", 32'(b_rv), 32'd0);
        chk("t5_rd_hold", 32'(b_rd), 32'h1234);

        // Random traffic against the model with a mid-stream reset
        for (int i = 0; i < 10000; i++) begin
            int   bias;
            logic rst_now;
            bias    = (((i / 250) % 2) == 0) ? 70 : 30;
            rst_now = (i == 5000);
            step(($urandom_range(99) < 32'(bias)), 16'($urandom),
                 ($urandom_range(99) < 32'(100 - bias)),
                 ($urandom_range(999) == 0), rst_now);
            if (rst_now) chk_reset_state("mid_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
